// File: rtl/l2_pmem_adapter.sv
// l2_pmem_adapter
//
// Memory-side responder for the L2 physical-memory port. Each accepted
// 256-bit line read or write is turned into one 4-beat, 64-bit burst on the
// burst memory interface. Every accepted request gets a single-cycle pmem_resp.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   pmem_read/write   line request, held by the requester until pmem_resp
//   pmem_address      line address, bits [4:0] ignored
//   pmem_wdata        write line, captured when the request is accepted
//   pmem_rdata        read line, valid while pmem_resp=1, held until the next
//                     read's first beat
//   pmem_resp         one-cycle completion pulse
//   mem_read/write    burst request towards memory
//   mem_address       line-aligned burst address
//   mem_burst_o       current write beat
//   mem_burst_i       read beat, valid with mem_resp
//   mem_resp          beat strobe, four per burst
//   rd_count/wr_count completed transaction counters
//
// Optional feature: define L2_ADAPTER_STATS_EN to build the completion
// counters. Without it, rd_count/wr_count are tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request; write wins when both are high
// RD_BURST | mem_read high, collecting four beats into pmem_rdata
// WR_BURST | mem_write high, presenting wbuf one beat at a time
// DONE     | pmem_resp pulse, back to IDLE unconditionally

module l2_pmem_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [63:0]  mem_burst_o,
    input  logic [63:0]  mem_burst_i,
    input  logic         mem_resp,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [1:0]     beat;
    logic [26:0]    addr_q;
    logic [255:0]   wbuf;
    logic [255:0]   rdata_q;
    logic [7:0]     beat_lsb;

    // Offset-within-line bits are deliberately dropped: bursts are line aligned.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[4:0];

    assign beat_lsb = {beat, 6'b0};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pmem_write) begin
                    state_next = WR_BURST;
                end else if (pmem_read) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                if (mem_resp && (beat == 2'd3)) begin
                    state_next = DONE;
                end
            end
            WR_BURST: begin
                if (mem_resp && (beat == 2'd3)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. mem_resp outside a burst state falls through the
    // default arm and changes nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat    <= 2'd0;
            addr_q  <= '0;
            wbuf    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pmem_write) begin
                        addr_q <= pmem_address[31:5];
                        wbuf   <= pmem_wdata;
                        beat   <= 2'd0;
                    end else if (pmem_read) begin
                        addr_q <= pmem_address[31:5];
                        beat   <= 2'd0;
                    end
                end
                RD_BURST: begin
                    if (mem_resp) begin
                        rdata_q[beat_lsb +: 64] <= mem_burst_i;
                        beat                    <= beat + 2'd1;
                    end
                end
                WR_BURST: begin
                    if (mem_resp) begin
                        beat <= beat + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pmem_resp   = 1'b0;
        mem_burst_o = '0;
        case (state)
            RD_BURST: mem_read = 1'b1;
            WR_BURST: begin
                mem_write   = 1'b1;
                mem_burst_o = wbuf[beat_lsb +: 64];
            end
            DONE:     pmem_resp = 1'b1;
            default: begin
            end
        endcase
    end

    assign mem_address = {addr_q, 5'b0};
    assign pmem_rdata  = rdata_q;

`ifdef L2_ADAPTER_STATS_EN
    // Remembers which kind of burst is in flight so DONE knows which counter to bump.
    logic           op_is_write;
    logic [31:0]    rd_count_q;
    logic [31:0]    wr_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_is_write <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            if (state == IDLE) begin
                if (pmem_write) begin
                    op_is_write <= 1'b1;
                end else if (pmem_read) begin
                    op_is_write <= 1'b0;
                end
            end
            if (state == DONE) begin
                if (op_is_write) begin
                    wr_count_q <= wr_count_q + 32'd1;
                end else begin
                    rd_count_q <= rd_count_q + 32'd1;
                end
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_l2_pmem_adapter.sv
// Testbench for l2_pmem_adapter. Inputs change and outputs are sampled on the
// falling edge; the DUT works on the rising edge.
module tb_l2_pmem_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_burst_o;
    logic [63:0]  mem_burst_i = '0;
    logic         mem_resp = 1'b0;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    l2_pmem_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_burst_o  (mem_burst_o),
        .mem_burst_i  (mem_burst_i),
        .mem_resp     (mem_resp),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_read;
        logic [255:0] line;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_errors = 0;
    int           rd_done = 0;
    int           wr_done = 0;
    logic [255:0] wcap = '0;

    localparam logic [255:0] LINE_RD1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_WR1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pmem_resp retires the oldest expected transaction.
    always @(negedge clk) begin
        if (rst && pmem_resp) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_resp", pmem_resp, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_read) begin
                    check_val("pmem_rdata", pmem_rdata, mon_e.line);
                    rd_done++;
                end else begin
                    check_val("write_line", wcap, mon_e.line);
                    wr_done++;
                end
            end
        end
    end

    // One full transaction, called on a falling edge with the DUT in IDLE.
    // gaps give the number of idle cycles before each beat.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] line,
                           input int g0, input int g1, input int g2, input int g3,
                           input int exp_lat);
        int t;
        int gaps[4];
        gaps = '{g0, g1, g2, g3};
        pmem_address = addr;
        if (wr) begin
            pmem_write = 1'b1;
            pmem_wdata = line;
        end else begin
            pmem_read = 1'b1;
        end
        sb_q.push_back('{is_read: !wr, line: line});
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(wr ? mem_write : mem_read) && t < 20);
        check_val("req_latency", t, exp_lat);
        check_val("other_req", wr ? mem_read : mem_write, 1'b0);
        check_val("mem_address", mem_address, {addr[31:5], 5'b0});
        if (wr) pmem_wdata = ~line;
        for (int b = 0; b < 4; b++) begin
            repeat (gaps[b]) @(negedge clk);
            if (wr) begin
                check_val("mem_burst_o", mem_burst_o, line[64*b +: 64]);
                wcap[64*b +: 64] = mem_burst_o;
            end
            check_val("resp_early", pmem_resp, 1'b0);
            mem_resp    = 1'b1;
            mem_burst_i = wr ? 64'h0 : line[64*b +: 64];
            @(negedge clk);
            mem_resp    = 1'b0;
        end
        check_val("resp_timing", pmem_resp, 1'b1);
        check_val("addr_stable", mem_address, {addr[31:5], 5'b0});
        if (wr) pmem_write = 1'b0;
        else    pmem_read  = 1'b0;
        @(negedge clk);
        check_val("resp_pulse", pmem_resp, 1'b0);
        check_val("idle_reqs", {mem_read, mem_write}, 2'b00);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_resp"}, pmem_resp, 1'b0);
        check_val({tag, "_reqs"}, {mem_read, mem_write}, 2'b00);
        check_val({tag, "_addr"}, mem_address, 32'h0);
        check_val({tag, "_wbeat"}, mem_burst_o, 64'h0);
        check_val({tag, "_rdata"}, pmem_rdata, 256'h0);
        check_val({tag, "_counts"}, {rd_count, wr_count}, 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_rd;
        int exp_wr;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Read with beats back to back after one idle cycle
        run_txn(1'b0, 32'h0000_1234, LINE_RD1, 1, 0, 0, 0, 1);

        // Write with gapped beats; read data must be held across it
        run_txn(1'b1, 32'h0000_2000, LINE_WR1, 2, 1, 0, 2, 1);
        check_val("rdata_held", pmem_rdata, LINE_RD1);

        // Read and write together: write first, held read follows right after
        pmem_read = 1'b1;
        run_txn(1'b1, 32'h0000_3040, {4{64'h0123_4567_89AB_CDEF}} ^ {192'h0, 64'h55}, 0, 0, 1, 0, 1);
        check_val("held_read", pmem_read, 1'b1);
        run_txn(1'b0, 32'h0000_3040, {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000},
                0, 2, 0, 0, 1);

        // Stray beats in IDLE change nothing
        for (int i = 0; i < 3; i++) begin
            mem_resp    = 1'b1;
            mem_burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            @(negedge clk);
            check_val("stray_rdata", pmem_rdata,
                      {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000});
            check_val("stray_reqs", {mem_read, mem_write, pmem_resp}, 3'b000);
        end
        mem_resp = 1'b0;

        // Reset in the middle of a read after two beats
        pmem_address = 32'h0000_8040;
        pmem_read    = 1'b1;
        @(negedge clk);
        check_val("abort_req", mem_read, 1'b1);
        for (int i = 0; i < 2; i++) begin
            mem_resp    = 1'b1;
            mem_burst_i = 64'h7777_0000_0000_0000 | 64'(i);
            @(negedge clk);
        end
        mem_resp  = 1'b0;
        rst       = 1'b0;
        pmem_read = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        rd_done = 0;
        wr_done = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_resp    = 1'b1;
            mem_burst_i = 64'h9999_0000_0000_0000 | 64'(i);
            @(negedge clk);
            check_val("post_reset_beat", {pmem_resp, mem_read}, 2'b00);
            check_val("post_reset_rdata", pmem_rdata, 256'h0);
        end
        mem_resp = 1'b0;
        @(negedge clk);

        // Mixed traffic after reset: 3 reads and 2 writes
        run_txn(1'b0, 32'h0001_0000, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0, 0, 0, 0, 1);
        run_txn(1'b1, 32'hFFFF_FFE7, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 1, 1, 1, 1, 1);
        run_txn(1'b0, 32'h8000_0020, {4{64'h5A5A_A5A5_0F0F_F0F0}} ^ {64'h1, 64'h2, 64'h3, 64'h4},
                3, 0, 0, 1, 1);
        run_txn(1'b1, 32'h0000_0000, ~LINE_WR1, 0, 0, 0, 0, 1);
        run_txn(1'b0, 32'h1234_5678, ~LINE_RD1, 0, 1, 0, 0, 1);

        check_val("retired_all", sb_q.size(), 0);
`ifdef L2_ADAPTER_STATS_EN
        exp_rd = 3;
        exp_wr = 2;
`else
        exp_rd = 0;
        exp_wr = 0;
`endif
        check_val("rd_count", rd_count, exp_rd);
        check_val("wr_count", wr_count, exp_wr);
        check_val("reads_retired", rd_done, 3);
        check_val("writes_retired", wr_done, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l2_pmem_adapter.md
# l2_pmem_adapter

Memory-side responder for the L2 cache controller's physical-memory port. It accepts 256-bit line read and write requests (`pmem_read`/`pmem_write`/`pmem_resp`) and converts each into one 4-beat, 64-bit burst transaction on the burst memory interface. It sits between `l2_control`/L2 datapath and main memory. It answers every accepted request with a single-cycle `pmem_resp`.

## Interface
Parameters: none (line = 256 b, beat = 64 b, 4 beats fixed).

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `pmem_read`  in  1  line read request, held until `pmem_resp`
- `pmem_write`  in  1  line write request, held until `pmem_resp`
- `pmem_address`  in  32  line address; bits [4:0] ignored
- `pmem_wdata`  in  256  write line, sampled at acceptance
- `pmem_rdata`  out  256  read line, valid while `pmem_resp`=1
- `pmem_resp`  out  1  one-cycle completion pulse
- `mem_read`  out  1  burst read request
- `mem_write`  out  1  burst write request
- `mem_address`  out  32  `{addr_q[31:5], 5'b0}`
- `mem_burst_o`  out  64  write beat
- `mem_burst_i`  in  64  read beat, valid when `mem_resp`=1
- `mem_resp`  in  1  beat strobe: high for exactly 4 cycles per burst, not necessarily consecutive
- `rd_count`, `wr_count`  out  32 each  completed transactions; only functional under `L2_ADAPTER_STATS_EN`

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE. There is a 2-bit beat counter `beat`.
- IDLE:
  - `pmem_write`=1 → latch address and `pmem_wdata`, set `beat`=0, go to WR_BURST.
  - Else `pmem_read`=1 → latch address, set `beat`=0, go to RD_BURST.
  - If both are high, write wins. The read is served after the requester re-presents it.
- RD_BURST:
  - `mem_read`=1.
  - On each `mem_resp`, write `mem_burst_i` into `pmem_rdata[64*beat +: 64]` and increment `beat`.
  - When `mem_resp` is high with `beat`=3, go to DONE.
- WR_BURST:
  - `mem_write`=1 and `mem_burst_o` = `wbuf[64*beat +: 64]`.
  - Increment `beat` on each `mem_resp`.
  - When `mem_resp` is high with `beat`=3, go to DONE.
- DONE: `pmem_resp`=1 for exactly one cycle, then go to IDLE unconditionally.
- Beat 0 is the lowest-order 64 bits of the line.
- `mem_resp` in IDLE or DONE is a protocol violation. It is ignored: no state or data change.
- `pmem_read`/`pmem_write` changes after acceptance are ignored until DONE.
- `mem_address` stays stable from the cycle after acceptance until leaving DONE.

## Timing
- Reset (`rst`=0 at a clock edge):
  - State → IDLE, `beat` → 0.
  - `pmem_rdata`, `wbuf`, address register → 0.
  - All outputs are 0 in the following cycle: `pmem_resp`, `mem_read`, `mem_write`, `mem_address`, `mem_burst_o`, counters.
  - Reset mid-burst abandons the transaction without a `pmem_resp`. Subsequent `mem_resp` beats land in IDLE and are ignored.
- `mem_read`, `mem_write`, `pmem_resp` and `mem_burst_o` are decoded from registered state only, with no combinational path from inputs.
- Latency:
  - Request seen in IDLE at cycle 0 → `mem_read`/`mem_write` high from cycle 1.
  - Fourth `mem_resp` at cycle N → `pmem_resp` at cycle N+1 → IDLE at N+2.
  - Minimum is 6 cycles when beats arrive on cycles 1–4.
- Back-to-back: a request held or re-asserted in the IDLE cycle after DONE is accepted. There is at least 1 idle cycle between transactions.
- `pmem_rdata` is held after DONE until the next read's first beat.

## Configuration
- `L2_ADAPTER_STATS_EN` defined:
  - `rd_count`/`wr_count` are 32-bit registers, incremented in the DONE cycle of a read/write.
  - They wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: `rd_count`/`wr_count` are tied to 0 and no counter flops exist.

## Test plan
- Read, beats on consecutive cycles:
  - Stimulus: `pmem_read`, address 0x0000_1234; memory returns beats 0x11…, 0x22…, 0x33…, 0x44… on cycles 2–5.
  - Response: `mem_address`=0x0000_1220; `pmem_resp` on cycle 6; `pmem_rdata`={0x44…,0x33…,0x22…,0x11…}.
- Write with gapped `mem_resp` (cycles 3, 5, 6, 9):
  - Stimulus: `pmem_wdata`=0xDDDD…_CCCC…_BBBB…_AAAA….
  - Response: `mem_burst_o` shows 0xAAAA… until the first beat, then 0xBBBB…, 0xCCCC…, 0xDDDD…; `pmem_resp` on cycle 10.
- `pmem_read` and `pmem_write` both high:
  - Response: the write burst runs first; the read is then accepted in the IDLE cycle after DONE.
- `rst`=0 mid-read after 2 beats:
  - Stimulus: memory supplies 2 more beats after reset.
  - Response: no `pmem_resp`; outputs 0; state IDLE; a following read completes correctly.
- Stray `mem_resp` in IDLE:
  - Response: no state change; `pmem_rdata` unchanged.
- With `L2_ADAPTER_STATS_EN`:
  - Stimulus: 3 reads and 2 writes.
  - Response: `rd_count`=3, `wr_count`=2.
  - Without the macro, both read 0.
